// File: rtl/addsub_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding,
// digit-count helper and counter-width helper.
package addsub_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int ndig_f(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter needs at least one bit even when a single digit covers the word.
    function automatic int cnt_w_f(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into
// its top bit so the caller can form the signed-overflow flag.
module addsub_digit
    import addsub_serial_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial WIDTH-bit adder/subtractor, LSB digit first, start/done handshake.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = ndig_f(WIDTH, DIGIT);
    localparam int CW   = cnt_w_f(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             sub_q, sub_d, carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             accept, ovf_now;
    logic [DIGIT-1:0] dig_x, dig_y, dig_s;
    logic             dig_co, dig_cmsb;

`ifdef ADDSUB_SAT_EN
    function automatic logic [WIDTH-1:0] sat_f(input logic a_neg);
        logic [WIDTH-1:0] min_neg;
        min_neg            = '0;
        min_neg[WIDTH-1]   = 1'b1;
        return a_neg ? min_neg : ~min_neg;
    endfunction
`endif

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x     (dig_x),
        .y     (dig_y),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            work_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Subtract is a + ~b + 1: invert b per digit and seed the carry with 1.
    always_comb begin
        accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);
        dig_x   = a_q[int'(cnt_q) * DIGIT +: DIGIT];
        dig_y   = b_q[int'(cnt_q) * DIGIT +: DIGIT] ^ {DIGIT{sub_q}};
        ovf_now = dig_cmsb ^ dig_co;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            sub_d   = sub;
            carry_d = sub ? 1'b1 : cin;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            work_d[int'(cnt_q) * DIGIT +: DIGIT] = dig_s;
            carry_d = dig_co;
            cnt_d   = cnt_q + 1'b1;
            // Results are loaded on the edge into DONE so they are valid with done.
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                cout_d = dig_co;
                ovf_d  = ovf_now;
`ifdef ADDSUB_SAT_EN
                sum_d  = ovf_now ? sat_f(a_q[WIDTH-1]) : work_d;
`else
                sum_d  = work_d;
`endif
            end
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed self-checking bench for addsub_serial (8/2 main instance plus
// 16-bit instances with DIGIT 1, 4 and 16).
module tb_addsub_serial;

    logic       clk, rst, start, sub, cin;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic        s16_start;
    logic [15:0] a16, b16;
    logic [2:0]  d16_busy, d16_done, d16_cout, d16_ovf;
    logic [15:0] d16_sum [3];

    int n_vec = 0;
    int n_err = 0;

`ifdef ADDSUB_SAT_EN
    localparam logic [7:0] EXP_7F01 = 8'h7F;
    localparam logic [7:0] EXP_8001 = 8'h80;
`else
    localparam logic [7:0] EXP_7F01 = 8'h80;
    localparam logic [7:0] EXP_8001 = 8'h7F;
`endif

    addsub_serial #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(1)) u_w16_d1 (
        .clk(clk), .rst(rst), .start(s16_start), .sub(1'b0), .a(a16), .b(b16), .cin(1'b0),
        .busy(d16_busy[0]), .done(d16_done[0]), .sum(d16_sum[0]), .cout(d16_cout[0]), .ovf(d16_ovf[0])
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_w16_d4 (
        .clk(clk), .rst(rst), .start(s16_start), .sub(1'b0), .a(a16), .b(b16), .cin(1'b0),
        .busy(d16_busy[1]), .done(d16_done[1]), .sum(d16_sum[1]), .cout(d16_cout[1]), .ovf(d16_ovf[1])
    );

    addsub_serial #(.WIDTH(16), .DIGIT(16)) u_w16_d16 (
        .clk(clk), .rst(rst), .start(s16_start), .sub(1'b0), .a(a16), .b(b16), .cin(1'b0),
        .busy(d16_busy[2]), .done(d16_done[2]), .sum(d16_sum[2]), .cout(d16_cout[2]), .ovf(d16_ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request in the current cycle; returns one negedge after the accepting edge.
    task automatic start_op(input logic [7:0] ia, input logic [7:0] ib,
                            input logic icin, input logic isub);
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = icin;
        sub   = isub;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat, output int nb);
        lat = lat0;
        nb  = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic icin, input logic isub,
                      input logic [7:0] es, input logic ec, input logic eo);
        int lat, nb;
        start_op(ia, ib, icin, isub);
        wait_done(1, lat, nb);
        check({tag, "_sum"},  {24'b0, sum}, {24'b0, es});
        check({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
        check({tag, "_ovf"},  {31'b0, ovf}, {31'b0, eo});
        check({tag, "_lat"},  lat, 32'd5);
        check({tag, "_busy"}, nb, 32'd4);
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int lat, nb, ndone;
        int lat16 [3];
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        s16_start = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum",  {24'b0, sum},  32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_ovf",  {31'b0, ovf},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        op("add",     8'h0B, 8'h68, 1'b0, 1'b0, 8'h73, 1'b0, 1'b0);
        op("addc",    8'h9B, 8'h58, 1'b1, 1'b0, 8'hF4, 1'b0, 1'b0);
        op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, EXP_7F01, 1'b0, 1'b1);
        op("sub",     8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        op("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, EXP_8001, 1'b1, 1'b1);

        // Start pulse with different operands during RUN must be ignored.
        start_op(8'h11, 8'h22, 1'b0, 1'b0);
        start = 1'b1; a = 8'h55; b = 8'h55; sub = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; sub = 1'b0;
        wait_done(2, lat, nb);
        check("ign_sum", {24'b0, sum}, 32'h33);
        check("ign_lat", lat, 32'd5);
        @(negedge clk);

        // Back-to-back: start held in the DONE cycle.
        start_op(8'h30, 8'h03, 1'b0, 1'b0);
        wait_done(1, lat, nb);
        check("b2b_first", {24'b0, sum}, 32'h33);
        start_op(8'h01, 8'h02, 1'b0, 1'b0);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        check("b2b_hold", {24'b0, sum}, 32'h33);
        wait_done(1, lat, nb);
        check("b2b_sum", {24'b0, sum}, 32'h03);
        check("b2b_lat", lat, 32'd5);
        @(negedge clk);

        // Asynchronous reset in cycle 2 of an operation.
        start_op(8'h40, 8'h41, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_sum",  {24'b0, sum},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_nodone", ndone, 32'd0);
        op("post_rst", 8'h05, 8'h06, 1'b0, 1'b0, 8'h0B, 1'b0, 1'b0);

        // 16-bit sweep across digit sizes.
        lat16 = '{0, 0, 0};
        a16 = 16'hFFFF; b16 = 16'h0001; s16_start = 1'b1;
        @(negedge clk);
        s16_start = 1'b0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (d16_done[i] && lat16[i] == 0) begin
                    lat16[i] = cyc;
                    check($sformatf("w16_%0d_sum", i),  {16'b0, d16_sum[i]}, 32'h0);
                    check($sformatf("w16_%0d_cout", i), {31'b0, d16_cout[i]}, 32'd1);
                    check($sformatf("w16_%0d_ovf", i),  {31'b0, d16_ovf[i]}, 32'd0);
                end
            end
            @(negedge clk);
        end
        check("w16_d1_lat",  lat16[0], 32'd17);
        check("w16_d4_lat",  lat16[1], 32'd5);
        check("w16_d16_lat", lat16[2], 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
